// File: rtl/apx_mul_pkg.sv
// Shared types and elaboration-time helpers for the apx_seq_mul shift-add multiplier.
package apx_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to count 0..dw inclusive.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

  // Keeps product columns [2*dw-1:trunc] and clears columns [trunc-1:0].
  function automatic logic [63:0] trunc_mask(input int dw, input int trunc);
    logic [63:0] keep_all;
    logic [63:0] keep_hi;
    keep_all = (64'd1 << (2 * dw)) - 64'd1;
    keep_hi  = ~64'd0 << trunc;
    return keep_all & keep_hi;
  endfunction

endpackage

// File: rtl/apx_mul_step.sv
// One shift-add iteration: conditionally adds the multiplicand to the accumulator.
// With APX_MUL_TRUNC_EN defined the low TRUNC columns of the partial product are zeroed.
module apx_mul_step
  import apx_mul_pkg::*;
#(
  parameter int DW    = 8,
  parameter int TRUNC = 4
) (
  input  logic [2*DW-1:0] acc,
  input  logic [2*DW-1:0] mcand,
  input  logic            mplier_lsb,
  output logic [2*DW-1:0] acc_next
);

`ifdef APX_MUL_TRUNC_EN
  localparam bit TRUNC_ON = 1'b1;
`else
  localparam bit TRUNC_ON = 1'b0;
`endif

  // An exact build uses an all-ones mask, so TRUNC=0 and the exact build coincide.
  localparam int              TRUNC_EFF = TRUNC_ON ? TRUNC : 0;
  localparam logic [63:0]     MASK_ALL  = trunc_mask(DW, TRUNC_EFF);
  localparam logic [2*DW-1:0] MASK      = MASK_ALL[2*DW-1:0];

  logic [2*DW-1:0] partial;

  assign partial  = mcand & MASK;
  assign acc_next = mplier_lsb ? (acc + partial) : acc;

endmodule

// File: rtl/apx_seq_mul.sv
// apx_seq_mul: iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Define APX_MUL_TRUNC_EN to build the approximate variant (low TRUNC columns dropped).
module apx_seq_mul
  import apx_mul_pkg::*;
#(
  parameter int DW    = 8,
  parameter int TRUNC = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [2*DW-1:0] o_prod
);

  localparam int            CW        = cnt_width(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  state_t          state_reg, state_next;
  logic [2*DW-1:0] mcand_reg, mcand_next;
  logic [DW-1:0]   mplier_reg, mplier_next;
  logic [2*DW-1:0] acc_reg, acc_next;
  logic [2*DW-1:0] step_acc;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            ready_reg, ready_next;
  logic            valid_reg, valid_next;

  apx_mul_step #(
    .DW    (DW),
    .TRUNC (TRUNC)
  ) u_step (
    .acc        (acc_reg),
    .mcand      (mcand_reg),
    .mplier_lsb (mplier_reg[0]),
    .acc_next   (step_acc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      ready_reg  <= 1'b1;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      ready_reg  <= ready_next;
      valid_reg  <= valid_next;
    end
  end

  // Handshake flags are computed alongside the state so both outputs come straight from flops.
  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    ready_next  = ready_reg;
    valid_next  = valid_reg;
    case (state_reg)
      IDLE: begin
        if (i_valid && ready_reg) begin
          state_next  = BUSY;
          mcand_next  = {{DW{1'b0}}, i_a};
          mplier_next = i_b;
          acc_next    = '0;
          cnt_next    = '0;
          ready_next  = 1'b0;
        end
      end
      BUSY: begin
        acc_next    = step_acc;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CW'(1);
        if (cnt_reg == LAST_STEP) begin
          state_next = DONE;
          valid_next = 1'b1;
        end
      end
      DONE: begin
        // Product and valid hold indefinitely until downstream takes them.
        if (i_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
          ready_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b1;
        valid_next = 1'b0;
      end
    endcase
  end

  assign o_ready = ready_reg;
  assign o_valid = valid_reg;
  assign o_prod  = acc_reg;

endmodule

// File: tb/tb_apx_seq_mul.sv
// Self-checking bench for apx_seq_mul (DW=8, TRUNC=4); the reference follows APX_MUL_TRUNC_EN.
module tb_apx_seq_mul;

  localparam int DW    = 8;
  localparam int TRUNC = 4;

  logic            i_clk;
  logic            i_rst;
  logic            i_valid;
  logic            o_ready;
  logic [DW-1:0]   i_a;
  logic [DW-1:0]   i_b;
  logic            o_valid;
  logic            i_ready;
  logic [2*DW-1:0] o_prod;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rand_mode = 1'b0;
  logic valid_prev = 1'b0;

  logic [15:0] exp_q[$];
  logic [15:0] exact_q[$];
  int          acc_q[$];
  int          hs_q[$];

  apx_seq_mul #(
    .DW    (DW),
    .TRUNC (TRUNC)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_prod  (o_prod)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference: sum of shifted multiplicands, with low columns cleared in the approximate build.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] s;
    logic [15:0] pp;
    s = 16'd0;
    for (int i = 0; i < DW; i++) begin
      if (b[i]) begin
        pp = 16'(a) << i;
`ifdef APX_MUL_TRUNC_EN
        pp = pp & ~16'((1 << TRUNC) - 1);
`endif
        s = s + pp;
      end
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge i_clk) begin
    if (i_rst) begin
      valid_prev <= 1'b0;
    end else begin
      if (o_valid && !valid_prev) begin
        if (acc_q.size() == 0) timeout_fail("valid_without_accept");
        else check("latency", cyc - acc_q.pop_front(), DW);
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_a, i_b));
        exact_q.push_back(16'(i_a) * 16'(i_b));
        acc_q.push_back(cyc + 1);
        $display("accept a=%0d b=%0d at edge %0d", i_a, i_b, cyc + 1);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_product");
        end else begin
          logic [15:0] e;
          logic [15:0] x;
          e = exp_q.pop_front();
          x = exact_q.pop_front();
          $display("product %0d expected %0d at edge %0d", o_prod, e, cyc + 1);
          check("prod", o_prod, e);
          check("prod_le_exact", 32'(o_prod <= x), 32'd1);
          hs_q.push_back(cyc + 1);
        end
      end
      valid_prev <= o_valid;
    end
  end

  always @(posedge i_clk) begin
    if (rand_mode) begin
      #1;
      i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n;
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    n = 0;
    forever begin
      @(negedge i_clk);
      if (o_ready) break;
      n++;
      if (n > 300) begin
        timeout_fail("send_accept");
        break;
      end
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    forever begin
      @(negedge i_clk);
      if (o_valid) break;
      n++;
      if (n > 50) begin
        timeout_fail("wait_valid");
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !o_valid) break;
      n++;
      if (n > 500) begin
        timeout_fail("drain");
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_prod"}, 32'(o_prod), 32'd0);
  endtask

  task automatic flush_scoreboard();
    exp_q.delete();
    exact_q.delete();
    acc_q.delete();
  endtask

  logic [7:0] b2b_a[3] = '{8'd200, 8'd17, 8'd99};
  logic [7:0] b2b_b[3] = '{8'd3, 8'd250, 8'd77};

  initial begin
    logic [15:0] bp_exp;
    int idx;
    int n;

    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_ready = 1'b0;

    // Reset and idle values.
    #2 i_rst = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("in_reset");
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check_reset_outputs("after_reset");

    // 13*11 with 20 cycles of backpressure in DONE.
    bp_exp = model(8'd13, 8'd11);
    send(8'd13, 8'd11);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      check("bp_prod", 32'(o_prod), 32'(bp_exp));
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_ready", 32'(o_ready), 32'd0);
    end
    @(posedge i_clk);
    #1 i_ready = 1'b1;
    drain();

    // Boundary operands.
    send(8'd255, 8'd255);
    drain();
    send(8'd0, 8'd200);
    drain();

    // Back-to-back with i_valid held high.
    hs_q.delete();
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_a     = b2b_a[0];
    i_b     = b2b_b[0];
    idx = 0;
    n   = 0;
    while (idx < 3 && n < 200) begin
      @(negedge i_clk);
      n++;
      if (o_ready) begin
        idx++;
        @(posedge i_clk);
        #1;
        if (idx < 3) begin
          i_a = b2b_a[idx];
          i_b = b2b_b[idx];
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    if (idx < 3) timeout_fail("b2b_accepts");
    drain();
    check("b2b_count", hs_q.size(), 3);
    check("b2b_gap0", hs_q[1] - hs_q[0], 10);
    check("b2b_gap1", hs_q[2] - hs_q[1], 10);

    // i_valid pulse while BUSY must be ignored.
    hs_q.delete();
    send(8'd21, 8'd3);
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_a     = 8'd7;
    i_b     = 8'd7;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    drain();
    repeat (12) @(negedge i_clk);
    check("busy_pulse_count", hs_q.size(), 1);

    // Asynchronous reset mid-BUSY.
    send(8'd100, 8'd100);
    @(negedge i_clk);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    flush_scoreboard();
    #1 check_reset_outputs("rst_busy");
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check_reset_outputs("rst_busy_after");

    // Asynchronous reset mid-DONE.
    i_ready = 1'b0;
    send(8'd9, 8'd9);
    wait_valid();
    #2 i_rst = 1'b1;
    flush_scoreboard();
    #1 check_reset_outputs("rst_done");
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check_reset_outputs("rst_done_after");

    // Random operands with random downstream stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0) repeat (2) @(posedge i_clk);
    end
    drain();
    rand_mode = 1'b0;
    @(posedge i_clk);
    #2 i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
